// File: rtl/cache_def.sv
// rtl/cache_def.sv - shared cache line and memory request types for the victim cache
package cache_def;

    localparam int VC_ENTRIES_DEF = 4;

    typedef struct packed {
        logic         valid;
        logic         dirty;
        logic [31:0]  addr;
        logic [127:0] data;
    } evict_data_type;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

endpackage

// File: rtl/vc_match.sv
// rtl/vc_match.sv - fully-associative line-address compare with one-hot to index encode
module vc_match #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]       valid_i,
    input  logic [N-1:0][27:0] lines_i,
    input  logic [27:0]        key_i,
    output logic               hit_o,
    output logic [IW-1:0]      idx_o
);

    logic [N-1:0] onehot;

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = valid_i[i] && (lines_i[i] == key_i);
            if (onehot[i]) begin
                hit_o = 1'b1;
                idx_o = idx_o | IW'(i);
            end
        end
    end

endmodule

// File: rtl/victim_cache.sv
// rtl/victim_cache.sv - fully-associative victim cache with dirty write-back; counters under VC_PERF_CNT_EN
module victim_cache import cache_def::*; #(
    parameter int VC_ENTRIES = VC_ENTRIES_DEF
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  evict_data_type evict_data_i,
    input  logic           lookup_valid_i,
    input  logic [31:0]    lookup_addr_i,
    output evict_data_type data_swap_o,
    output logic           vc_miss_o,
    output logic           full_o,
    output logic           stall_o,
    output mem_req_type    wb_req_o,
    input  logic           wb_ready_i,
    output logic [31:0]    vc_hit_cnt_o,
    output logic [31:0]    vc_miss_cnt_o
);

    localparam int IW = $clog2(VC_ENTRIES);
    localparam logic [0:0] ST_IDLE       = 1'b0;
    localparam logic [0:0] ST_WRITE_BACK = 1'b1;

    logic [0:0]                     state_q;
    logic [IW-1:0]                  fifo_q;
    logic [VC_ENTRIES-1:0]          valid_q;
    logic [VC_ENTRIES-1:0]          dirty_q;
    logic [31:0]                    addr_q [VC_ENTRIES];
    logic [127:0]                   data_q [VC_ENTRIES];
    logic [VC_ENTRIES-1:0][27:0]    lines;

    logic          lookup_fire, evict_fire;
    logic          lk_hit, ev_hit;
    logic [IW-1:0] lk_idx, ev_idx;
    logic          free_found, ins_replace, wb_needed;
    logic [IW-1:0] free_idx, ins_idx;
    logic          unused_low_bits;

    assign unused_low_bits = ^{lookup_addr_i[3:0]};

    always_comb begin
        for (int i = 0; i < VC_ENTRIES; i++) begin
            lines[i] = addr_q[i][31:4];
        end
    end

    assign stall_o     = (state_q == ST_WRITE_BACK);
    assign lookup_fire = lookup_valid_i && !stall_o;
    assign evict_fire  = evict_data_i.valid && !stall_o;
    assign full_o      = &valid_q;

    vc_match #(.N(VC_ENTRIES), .IW(IW)) u_lookup_match (
        .valid_i (valid_q),
        .lines_i (lines),
        .key_i   (lookup_addr_i[31:4]),
        .hit_o   (lk_hit),
        .idx_o   (lk_idx)
    );

    vc_match #(.N(VC_ENTRIES), .IW(IW)) u_evict_match (
        .valid_i (valid_q),
        .lines_i (lines),
        .key_i   (evict_data_i.addr[31:4]),
        .hit_o   (ev_hit),
        .idx_o   (ev_idx)
    );

    // Slot priority: same line, then the slot a same-cycle hit frees, then lowest free, then FIFO victim.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        ins_replace = 1'b0;
        for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
        if (ev_hit) begin
            ins_idx = ev_idx;
        end else if (lookup_fire && lk_hit) begin
            ins_idx = lk_idx;
        end else if (free_found) begin
            ins_idx = free_idx;
        end else begin
            ins_idx     = fifo_q;
            ins_replace = 1'b1;
        end
        wb_needed = evict_fire && ins_replace && dirty_q[fifo_q];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            fifo_q      <= '0;
            valid_q     <= '0;
            data_swap_o <= '0;
            vc_miss_o   <= 1'b0;
            wb_req_o    <= '0;
        end else begin
            data_swap_o <= '0;
            vc_miss_o   <= 1'b0;
            if (lookup_fire) begin
                if (lk_hit) begin
                    data_swap_o.valid <= 1'b1;
                    data_swap_o.dirty <= dirty_q[lk_idx];
                    data_swap_o.addr  <= addr_q[lk_idx];
                    data_swap_o.data  <= data_q[lk_idx];
                    valid_q[lk_idx]   <= 1'b0;
                end else begin
                    vc_miss_o <= 1'b1;
                end
            end
            // Placed after the lookup invalidate so a swapped-in line wins the same slot.
            if (evict_fire) begin
                valid_q[ins_idx] <= 1'b1;
                if (ins_replace) begin
                    fifo_q <= fifo_q + IW'(1);
                end
                if (wb_needed) begin
                    wb_req_o.addr  <= addr_q[fifo_q];
                    wb_req_o.data  <= data_q[fifo_q];
                    wb_req_o.rw    <= 1'b1;
                    wb_req_o.valid <= 1'b1;
                    state_q        <= ST_WRITE_BACK;
                end
            end
            if (state_q == ST_WRITE_BACK && wb_ready_i) begin
                wb_req_o <= '0;
                state_q  <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (evict_fire) begin
            addr_q[ins_idx]  <= evict_data_i.addr;
            data_q[ins_idx]  <= evict_data_i.data;
            dirty_q[ins_idx] <= evict_data_i.dirty;
        end
    end

`ifdef VC_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (lookup_fire) begin
            if (lk_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign vc_hit_cnt_o  = hit_cnt_q;
    assign vc_miss_cnt_o = miss_cnt_q;
`else
    assign vc_hit_cnt_o  = '0;
    assign vc_miss_cnt_o = '0;
`endif

endmodule
